// File: rtl/cpu_defs.sv
// Shared CPU definitions: MDU opcodes, default latencies and result payload.
package cpu_defs;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned MDU_OP_W = 3;

    localparam logic [MDU_OP_W-1:0] MDU_NOP   = 3'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd5;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd6;

    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } mdu_res_t;

    typedef enum logic {
        MDU_ST_IDLE = 1'b0,
        MDU_ST_BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_unit_if.sv
// E-stage to MDU bus: operands and op code in, busy and HI/LO out.
interface mdu_unit_if;
    import cpu_defs::*;

    logic                start;
    logic [MDU_OP_W-1:0] mdu_op;
    logic [XLEN-1:0]     rs_val;
    logic [XLEN-1:0]     rt_val;
    logic                rd_sel;
    logic                busy;
    logic [XLEN-1:0]     hi;
    logic [XLEN-1:0]     lo;
    logic [XLEN-1:0]     mdu_rd;

    modport master (
        output start, mdu_op, rs_val, rt_val, rd_sel,
        input  busy, hi, lo, mdu_rd
    );

    modport slave (
        input  start, mdu_op, rs_val, rt_val, rd_sel,
        output busy, hi, lo, mdu_rd
    );

endinterface

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing a {hi,lo} result.
module mdu_calc
    import cpu_defs::*;
(
    input  logic [MDU_OP_W-1:0] op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output mdu_res_t            res,
    output logic                div_zero
);

    logic [2*XLEN-1:0] prod_u;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   b_safe;
    logic [XLEN-1:0]   q_u;
    logic [XLEN-1:0]   r_u;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   q_mag;
    logic [XLEN-1:0]   r_mag;
    logic [XLEN-1:0]   q_s;
    logic [XLEN-1:0]   r_s;

    // Signed divide works on magnitudes; 0x80000000/-1 wraps back to 0x80000000.
    always_comb begin
        prod_u = {XLEN'(0), a} * {XLEN'(0), b};
        prod_s = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};

        b_safe = (b == '0) ? XLEN'(1) : b;
        q_u    = a / b_safe;
        r_u    = a % b_safe;

        a_neg  = a[XLEN-1];
        b_neg  = b[XLEN-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        if (b_mag == '0) begin
            b_mag = XLEN'(1);
        end
        q_mag  = a_mag / b_mag;
        r_mag  = a_mag % b_mag;
        q_s    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        r_s    = a_neg ? -r_mag : r_mag;

        res      = '0;
        div_zero = 1'b0;
        case (op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV: begin
                res.hi   = r_s;
                res.lo   = q_s;
                div_zero = (b == '0);
            end
            MDU_DIVU: begin
                res.hi   = r_u;
                res.lo   = q_u;
                div_zero = (b == '0);
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: fixed-latency ops into private HI/LO with busy handshake.
module mdu_unit
    import cpu_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    mdu_unit_if.slave  bus
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mdu_res_t          shadow_q, shadow_d;
    logic              commit_ok_q, commit_ok_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              busy_q, busy_d;
    logic [XLEN-1:0]   mdu_rd_c;

    mdu_res_t          calc_res;
    logic              calc_div_zero;

    mdu_calc u_calc (
        .op       (bus.mdu_op),
        .a        (bus.rs_val),
        .b        (bus.rt_val),
        .res      (calc_res),
        .div_zero (calc_div_zero)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= MDU_ST_IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            commit_ok_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            commit_ok_q <= commit_ok_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state: accept in IDLE, count down in BUSY, commit on the last edge
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        commit_ok_d = commit_ok_q;
        hi_d        = hi_q;
        lo_d        = lo_q;

        case (state_q)
            MDU_ST_IDLE: begin
                if (bus.start) begin
                    case (bus.mdu_op)
                        MDU_MULT, MDU_MULTU: begin
                            state_d     = MDU_ST_BUSY;
                            cnt_d       = CNT_W'(MULT_CYCLES);
                            shadow_d    = calc_res;
                            commit_ok_d = 1'b1;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            state_d     = MDU_ST_BUSY;
                            cnt_d       = CNT_W'(DIV_CYCLES);
                            shadow_d    = calc_res;
                            commit_ok_d = !calc_div_zero;
                        end
                        MDU_MTHI: hi_d = bus.rs_val;
                        MDU_MTLO: lo_d = bus.rs_val;
                        default: ;
                    endcase
                end
            end
            MDU_ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = MDU_ST_IDLE;
                    commit_ok_d = 1'b0;
                    if (commit_ok_q) begin
                        hi_d = shadow_q.hi;
                        lo_d = shadow_q.lo;
                    end
                end
            end
            default: state_d = MDU_ST_IDLE;
        endcase

        busy_d = (cnt_d != '0);
    end

    // Outputs: registered HI/LO/busy, combinational MFHI/MFLO read mux
    always_comb begin
        mdu_rd_c = bus.rd_sel ? lo_q : hi_q;
    end

    assign bus.busy   = busy_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.mdu_rd = mdu_rd_c;

endmodule
